// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one I2C byte-write engine between NUM_REQ requesters
//   clk, reset (sync, active-high); req/req_addr/req_data from clients; ack/err pulses back to the owner;
//   eng_start/eng_addr/eng_data to the engine, eng_done/eng_nack from it; busy, owner, timeout_flag status.
//   Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic                 eng_start,
  output logic [6:0]           eng_addr,
  output logic [7:0]           eng_data,
  input  logic                 eng_done,
  input  logic                 eng_nack,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_flag
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
  state_t state;
  logic [2:0] rr_ptr, win;
  logic [3:0] idx;
  logic found, to_hit;
  logic [7:0] gap_cnt;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit = state == WAIT && !eng_done && to_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset) begin
      to_cnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT) ? to_cnt + 16'd1 : '0;
      if (to_hit) timeout_flag <= 1'b1;
    end
`else
  assign to_hit = 1'b0;
  assign timeout_flag = 1'b0;
`endif
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 4'(rr_ptr) + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!found && (req & (NUM_REQ'(1) << idx)) != '0) begin
        found = 1'b1;
        win = idx[2:0];
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      ack <= '0;
      err <= 1'b0;
      eng_start <= 1'b0;
      eng_addr <= '0;
      eng_data <= '0;
      busy <= 1'b0;
      gap_cnt <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      eng_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          owner <= win;
          eng_addr <= 7'(req_addr >> (7 * win));
          eng_data <= 8'(req_data >> (8 * win));
          state <= ISSUE;
          busy <= 1'b1;
        end
        ISSUE: begin
          eng_start <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (eng_done || to_hit) begin
          ack <= NUM_REQ'(1) << owner;
          err <= !eng_done || eng_nack;
          rr_ptr <= (owner == 3'(NUM_REQ - 1)) ? 3'd0 : owner + 3'd1;
          gap_cnt <= 8'(GAP_CYCLES - 1);
          state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          busy <= GAP_CYCLES != 0;
        end
        default: if (gap_cnt == '0) begin
          state <= IDLE;
          busy <= 1'b0;
        end else gap_cnt <= gap_cnt - 8'd1;
      endcase
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: self-checking bench for i2c_txn_arbiter with a round-robin reference model
module tb_i2c_txn_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*7-1:0] req_addr = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic err, eng_start, busy, timeout_flag, eng_done, eng_nack;
  logic [6:0] eng_addr;
  logic [7:0] eng_data;
  logic [2:0] owner;
  int checks = 0;
  int failures = 0;
  int m_rr = 0;
  bit eng_auto = 1'b1;
  bit manual_done = 1'b0;
  bit nack_cfg = 1'b0;
  int eng_lat = 5;
  always #5 clk = ~clk;
  i2c_txn_arbiter #(.NUM_REQ(N), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .err(err), .eng_start(eng_start), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_done(eng_done), .eng_nack(eng_nack), .busy(busy), .owner(owner), .timeout_flag(timeout_flag)
  );
  initial begin
    eng_done = 1'b0;
    eng_nack = 1'b0;
    forever begin
      @(posedge clk); #2;
      eng_done = manual_done;
      eng_nack = 1'b0;
      if (eng_auto && eng_start === 1'b1) begin
        repeat (eng_lat) begin
          @(posedge clk); #2;
          eng_done = 1'b0;
        end
        eng_done = 1'b1;
        eng_nack = nack_cfg;
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  function automatic int pick(logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction
  task automatic wait_start(output bit ok);
    int n = 0;
    while (eng_start !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    ok = eng_start === 1'b1;
  endtask
  task automatic wait_ack(output bit ok);
    int n = 0;
    while (ack === '0 && n < 100) begin
      tick();
      n++;
    end
    ok = ack !== '0;
  endtask
  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    ok = busy === 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (owner !== 3'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++; if (ack !== '0 || err !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b/%b exp=0000/0", ack, err); end
    checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", eng_start); end
    checks++; if (eng_addr !== 7'h0 || eng_data !== 8'h0) begin failures++; $display("FAIL reset_eng got=%h/%h exp=0/0", eng_addr, eng_data); end
    checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL reset_tflag got=%b exp=0", timeout_flag); end
    reset = 1'b0;
    m_rr = 0;
    tick();
  endtask
  task automatic test_single();
    int bad = 0;
    req_addr = '0;
    req_data = '0;
    req_addr[13:7] = 7'h32;
    req_data[15:8] = 8'h0A;
    eng_lat = 18;
    nack_cfg = 1'b0;
    req = 4'b0010;
    tick();
    checks++; if (owner !== 3'd1 || busy !== 1'b1 || eng_start !== 1'b0) begin failures++; $display("FAIL single_grant got owner=%0d busy=%b start=%b exp 1/1/0", owner, busy, eng_start); end
    tick();
    checks++; if (eng_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", eng_start); end
    checks++; if (eng_addr !== 7'h32 || eng_data !== 8'h0A) begin failures++; $display("FAIL single_eng got=%h/%h exp=32/0a", eng_addr, eng_data); end
    for (int c = 3; c <= 20; c++) begin
      tick();
      if (ack !== '0 || eng_start !== 1'b0 || eng_addr !== 7'h32 || eng_data !== 8'h0A) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_wait got=%0d bad cycles exp=0", bad); end
    tick();
    checks++; if (ack !== 4'b0010 || err !== 1'b0) begin failures++; $display("FAIL single_ack got=%b/%b exp=0010/0", ack, err); end
    req = '0;
    m_rr = 2;
    tick();
    checks++; if (busy !== 1'b1 || ack !== '0) begin failures++; $display("FAIL single_gap got busy=%b ack=%b exp 1/0000", busy, ack); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask
  task automatic test_round_robin();
    bit ok;
    int e;
    logic [N-1:0] served = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_rr = 0;
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7] = 7'($urandom);
      req_data[8*i +: 8] = 8'($urandom);
    end
    eng_lat = 5;
    nack_cfg = 1'b0;
    req = '1;
    for (int g = 0; g < 6; g++) begin
      e = pick(req);
      if (g % N == 0) served = '0;
      wait_start(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_start_timeout grant=%0d", g); end
      checks++; if (owner !== 3'(g % N) || owner !== 3'(e)) begin failures++; $display("FAIL rr_owner grant=%0d got=%0d exp=%0d", g, owner, e); end
      checks++; if (eng_addr !== req_addr[7*e +: 7] || eng_data !== req_data[8*e +: 8]) begin failures++; $display("FAIL rr_eng got=%h/%h exp=%h/%h", eng_addr, eng_data, req_addr[7*e +: 7], req_data[8*e +: 8]); end
      wait_ack(ok);
      checks++; if (ack !== N'(1) << e || err !== 1'b0) begin failures++; $display("FAIL rr_ack grant=%0d got=%b/%b exp=%b/0", g, ack, err, N'(1) << e); end
      checks++; if (served[e]) begin failures++; $display("FAIL rr_fair requester %0d got twice in window exp once", e); end
      served[e] = 1'b1;
      m_rr = (e + 1) % N;
      tick();
    end
    req = '0;
  endtask
  task automatic test_nack();
    bit ok;
    wait_idle(ok);
    eng_lat = 3;
    nack_cfg = 1'b1;
    req = 4'b1000;
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL nack_start_timeout"); end
    wait_ack(ok);
    checks++; if (ack !== 4'b1000 || err !== 1'b1) begin failures++; $display("FAIL nack_ack got=%b/%b exp=1000/1", ack, err); end
    tick();
    checks++; if (ack !== '0 || err !== 1'b0) begin failures++; $display("FAIL nack_pulse got=%b/%b exp=0000/0", ack, err); end
    m_rr = 0;
    nack_cfg = 1'b0;
    req = 4'b1001;
    wait_start(ok);
    checks++; if (owner !== 3'(pick(req))) begin failures++; $display("FAIL nack_rr got=%0d exp=%0d", owner, pick(req)); end
    wait_ack(ok);
    checks++; if (ack !== 4'b0001 || err !== 1'b0) begin failures++; $display("FAIL nack_next_ack got=%b/%b exp=0001/0", ack, err); end
    m_rr = 1;
    req = '0;
  endtask
  task automatic test_random();
    bit ok;
    int e;
    logic [N-1:0] r;
    bit nk;
    for (int t = 0; t < 16; t++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      nk = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        req_addr[7*i +: 7] = 7'($urandom);
        req_data[8*i +: 8] = 8'($urandom);
      end
      eng_lat = $urandom_range(1, 8);
      nack_cfg = nk;
      e = pick(r);
      req = r;
      wait_start(ok);
      checks++; if (!ok || owner !== 3'(e)) begin failures++; $display("FAIL rand_owner t=%0d req=%b got=%0d exp=%0d", t, r, owner, e); end
      checks++; if (eng_addr !== req_addr[7*e +: 7] || eng_data !== req_data[8*e +: 8]) begin failures++; $display("FAIL rand_eng t=%0d got=%h/%h exp=%h/%h", t, eng_addr, eng_data, req_addr[7*e +: 7], req_data[8*e +: 8]); end
      wait_ack(ok);
      checks++; if (ack !== N'(1) << e || err !== nk) begin failures++; $display("FAIL rand_ack t=%0d got=%b/%b exp=%b/%b", t, ack, err, N'(1) << e, nk); end
      m_rr = (e + 1) % N;
      req = '0;
    end
    nack_cfg = 1'b0;
  endtask
  task automatic test_hold_after_grant();
    bit ok;
    int bad = 0;
    logic [6:0] a;
    logic [7:0] d;
    wait_idle(ok);
    a = 7'($urandom);
    d = 8'($urandom);
    req_addr[6:0] = a;
    req_data[7:0] = d;
    eng_lat = 6;
    req = 4'b0001;
    wait_start(ok);
    checks++; if (!ok) begin failures++; $display("FAIL hold_start_timeout"); end
    req = '0;
    req_addr[6:0] = ~a;
    req_data[7:0] = ~d;
    while (ack === '0 && bad < 100) begin
      if (eng_addr !== a || eng_data !== d) bad = bad + 1000;
      tick();
      bad++;
    end
    checks++; if (bad >= 100) begin failures++; $display("FAIL hold_eng got=%h/%h exp=%h/%h", eng_addr, eng_data, a, d); end
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL hold_ack got=%b exp=0001", ack); end
    m_rr = 1;
  endtask
  task automatic test_spurious_done();
    bit ok;
    int bad = 0;
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL spur_idle_timeout"); end
    eng_auto = 1'b0;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    repeat (4) begin
      tick();
      if (ack !== '0 || busy !== 1'b0 || err !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL spur_idle got=%0d bad cycles exp=0", bad); end
    eng_auto = 1'b1;
  endtask
  task automatic test_reset_mid_wait();
    bit ok;
    eng_auto = 1'b0;
    eng_lat = 4;
    req = 4'b0100;
    wait_start(ok);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || eng_start !== 1'b0 || owner !== 3'd0 || ack !== '0) begin failures++; $display("FAIL rst_wait got busy=%b start=%b owner=%0d ack=%b exp 0/0/0/0000", busy, eng_start, owner, ack); end
    reset = 1'b0;
    m_rr = 0;
    eng_auto = 1'b1;
    wait_start(ok);
    checks++; if (!ok || owner !== 3'd2) begin failures++; $display("FAIL rst_regrant got=%0d exp=2", owner); end
    wait_ack(ok);
    checks++; if (ack !== 4'b0100) begin failures++; $display("FAIL rst_ack got=%b exp=0100", ack); end
    m_rr = 3;
    req = '0;
  endtask
  task automatic test_timeout();
    bit ok;
    int bad = 0;
    wait_idle(ok);
    eng_auto = 1'b0;
    req = 4'b0010;
    wait_start(ok);
`ifdef I2C_ARB_TIMEOUT_EN
    repeat (15) begin
      tick();
      if (ack !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL to_early got=%0d acks exp=0", bad); end
    tick();
    checks++; if (ack !== 4'b0010 || err !== 1'b1 || timeout_flag !== 1'b1) begin failures++; $display("FAIL to_fire got ack=%b err=%b tf=%b exp 0010/1/1", ack, err, timeout_flag); end
    req = '0;
    wait_idle(ok);
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (ack !== '0) bad++;
    end
    checks++; if (bad != 0 || timeout_flag !== 1'b1) begin failures++; $display("FAIL to_late got acks=%0d tf=%b exp 0/1", bad, timeout_flag); end
    reset = 1'b1;
    tick();
    checks++; if (timeout_flag !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", timeout_flag); end
`else
    repeat (100) begin
      tick();
      if (busy !== 1'b1 || timeout_flag !== 1'b0 || ack !== '0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL no_to got=%0d bad cycles exp=0", bad); end
    req = '0;
    reset = 1'b1;
    tick();
`endif
    req = '0;
    reset = 1'b0;
    m_rr = 0;
    eng_auto = 1'b1;
    tick();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nack();
    test_random();
    test_hold_after_grant();
    test_spurious_done();
    test_reset_mid_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
